// File: rtl/video_mode_ctrl.sv
// rtl/video_mode_ctrl.sv - classifies Dreamcast sync into 240p/480/PAL and sequences mode lock
// Build option SYNC_GLITCH_FILTER_EN: hsync low must persist two clocks to count as an edge.
module video_mode_ctrl #(
  parameter int STABLE_FRAMES = 3,
  parameter int LOSS_TIMEOUT  = 108000000,
  parameter int CNT_W         = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             _hsync,
  input  logic             _vsync,
  input  logic             force_generate_req,
  output logic             add_line,
  output logic             is_pal,
  output logic             mode_valid,
  output logic             resync,
  output logic             generate_timing,
  output logic             mode_change,
  output logic [CNT_W-1:0] frame_lines
);
  localparam int                LOSS_W     = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST  = LOSS_W'(LOSS_TIMEOUT - 1);
  localparam logic [3:0]        MATCH_LOCK = 4'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0]  LINE_MAX   = '1;

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED, LOST} state_t;
  typedef enum logic [1:0] {CBAD, C240P, C480, CPAL} class_t;

  logic h_q, v_q, hsync_edge, frame_edge;

`ifdef SYNC_GLITCH_FILTER_EN
  logic h_q2, v_q2;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q  <= 1'b1;
      v_q  <= 1'b1;
      h_q2 <= 1'b1;
      v_q2 <= 1'b1;
    end else begin
      h_q  <= _hsync;
      v_q  <= _vsync;
      h_q2 <= h_q;
      v_q2 <= v_q;
    end
  end
  // Edge qualifies on the second low clock; vsync is judged one clock later to stay aligned.
  assign hsync_edge = h_q2 & ~h_q & ~_hsync;
  assign frame_edge = hsync_edge & v_q2 & ~v_q;
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q <= 1'b1;
      v_q <= 1'b1;
    end else begin
      h_q <= _hsync;
      v_q <= _vsync;
    end
  end
  assign hsync_edge = h_q & ~_hsync;
  assign frame_edge = hsync_edge & v_q & ~_vsync;
`endif

  logic [CNT_W-1:0]  line_cnt;
  logic [LOSS_W-1:0] loss_cnt;
  logic              loss_event;
  class_t            frame_class;

  always_comb begin
    frame_class = CBAD;
    if (line_cnt == CNT_W'(262))      frame_class = C240P;
    else if (line_cnt == CNT_W'(524)) frame_class = C480;
    else if (line_cnt == CNT_W'(624)) frame_class = CPAL;
  end

  // A live hsync edge always beats a timeout landing on the same clock.
  assign loss_event = (loss_cnt == LOSS_LAST) && !hsync_edge;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_cnt    <= '0;
      frame_lines <= '0;
      loss_cnt    <= '0;
    end else begin
      if (hsync_edge) begin
        loss_cnt <= '0;
        if (frame_edge) begin
          frame_lines <= line_cnt;
          line_cnt    <= '0;
        end else if (line_cnt != LINE_MAX) begin
          line_cnt <= line_cnt + CNT_W'(1);
        end
      end else if (loss_cnt != LOSS_LAST) begin
        loss_cnt <= loss_cnt + LOSS_W'(1);
      end
    end
  end

  state_t     state, state_nx;
  class_t     cand, cand_nx, committed;
  logic [3:0] match, match_nx;
  logic       enter_lock;

  always_comb begin
    state_nx   = state;
    cand_nx    = cand;
    match_nx   = match;
    enter_lock = 1'b0;
    if (loss_event) begin
      state_nx = LOST;
    end else if (hsync_edge) begin
      case (state)
        SEARCH, LOCKING: begin
          if (frame_edge) begin
            if (frame_class == CBAD) begin
              state_nx = SEARCH;
            end else begin
              if (state == LOCKING && frame_class == cand) begin
                match_nx = match + 4'd1;
              end else begin
                cand_nx  = frame_class;
                match_nx = 4'd1;
              end
              if (match_nx >= MATCH_LOCK) begin
                state_nx   = LOCKED;
                enter_lock = 1'b1;
              end else begin
                state_nx = LOCKING;
              end
            end
          end
        end
        LOCKED: begin
          if (frame_edge && frame_class != cand) state_nx = SEARCH;
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      cand        <= CBAD;
      match       <= '0;
      committed   <= CBAD;
      add_line    <= 1'b0;
      is_pal      <= 1'b0;
      mode_change <= 1'b0;
    end else begin
      state       <= state_nx;
      cand        <= cand_nx;
      match       <= match_nx;
      mode_change <= enter_lock && (cand_nx != committed);
      if (enter_lock) begin
        committed <= cand_nx;
        add_line  <= (cand_nx == C240P);
        is_pal    <= (cand_nx == CPAL);
      end
    end
  end

  assign resync          = (state != LOCKED);
  assign mode_valid      = (state == LOCKED);
  assign generate_timing = (state == LOST) | force_generate_req;
endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb/tb_video_mode_ctrl.sv - self-checking bench for video_mode_ctrl against a sync-rule model
module tb_video_mode_ctrl;
  localparam int SF = 3;
  localparam int LT = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        _hsync = 1'b1;
  logic        _vsync = 1'b1;
  logic        force_generate_req = 1'b0;
  logic        add_line, is_pal, mode_valid, resync, generate_timing, mode_change;
  logic [11:0] frame_lines;

  int checks = 0;
  int errors = 0;
  int mc_count = 0;

  video_mode_ctrl #(.STABLE_FRAMES(SF), .LOSS_TIMEOUT(LT), .CNT_W(12)) dut (
    .clock(clock), .reset(reset), ._hsync(_hsync), ._vsync(_vsync),
    .force_generate_req(force_generate_req), .add_line(add_line), .is_pal(is_pal),
    .mode_valid(mode_valid), .resync(resync), .generate_timing(generate_timing),
    .mode_change(mode_change), .frame_lines(frame_lines)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: modes 0 search, 1 locking, 2 locked, 3 lost; classes 0 bad, 1 240p, 2 480, 3 pal.
  int   m_st, m_cand, m_streak, m_committed, m_lines, m_since, cls;
  int   m_frame_lines;
  bit   m_add, m_pal, m_mc, he, fe;
  bit   hp1, hp2, vp1, vp2;

  function automatic int classify(input int n);
    case (n)
      262:     return 1;
      524:     return 2;
      624:     return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_st = 0; m_cand = 0; m_streak = 0; m_committed = 0;
      m_lines = 0; m_since = 0; m_frame_lines = 0;
      m_add = 0; m_pal = 0; m_mc = 0;
      hp1 = 1; hp2 = 1; vp1 = 1; vp2 = 1;
    end else begin
`ifdef SYNC_GLITCH_FILTER_EN
      he = hp2 && !hp1 && !_hsync;
      fe = he && vp2 && !vp1;
`else
      he = hp1 && !_hsync;
      fe = he && vp1 && !_vsync;
`endif
      hp2 = hp1; hp1 = _hsync; vp2 = vp1; vp1 = _vsync;
      m_mc = 0;
      m_since++;
      if (he) begin
        cls = classify(m_lines);
        if (fe) begin
          m_frame_lines = m_lines;
          m_lines = 0;
        end else if (m_lines < 4095) begin
          m_lines++;
        end
        m_since = 0;
        if (m_st == 3) begin
          m_st = 0;
        end else if (fe) begin
          if (m_st == 2) begin
            if (cls != m_cand) m_st = 0;
          end else if (cls == 0) begin
            m_st = 0;
          end else begin
            if (m_st == 1 && cls == m_cand) m_streak++;
            else begin m_cand = cls; m_streak = 1; end
            if (m_streak >= SF) begin
              m_st = 2;
              m_mc = (m_cand != m_committed);
              m_committed = m_cand;
              m_add = (m_cand == 1);
              m_pal = (m_cand == 3);
            end else begin
              m_st = 1;
            end
          end
        end
      end else if (m_since >= LT) begin
        m_st = 3;
      end
    end
  end

  always @(negedge clock) begin
    check("add_line", add_line, m_add);
    check("is_pal", is_pal, m_pal);
    check("mode_valid", mode_valid, m_st == 2);
    check("resync", resync, m_st != 2);
    check("generate_timing", generate_timing, (m_st == 3) || force_generate_req);
    check("mode_change", mode_change, m_mc);
    check("frame_lines", frame_lines, m_frame_lines);
    if (mode_change === 1'b1) mc_count++;
  end

  task automatic cyc(input bit h, input bit v);
    _hsync = h;
    _vsync = v;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_frame(input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      bit v;
      v = (i < 3) ? 1'b0 : 1'b1;
      cyc(0, v); cyc(0, v); cyc(1, v); cyc(glitch ? 1'b0 : 1'b1, v); cyc(1, v);
    end
  endtask

  task automatic frames(input int n, input int count);
    for (int k = 0; k < count; k++) drive_frame(n, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_resync", resync, 1);
    check("reset_frame_lines", frame_lines, 0);
    reset = 1'b0;

    frames(525, 4);
    check("t1_mode_valid", mode_valid, 1);
    check("t1_resync", resync, 0);
    check("t1_add_line", add_line, 0);
    check("t1_is_pal", is_pal, 0);
    check("t1_frame_lines", frame_lines, 524);
    check("t1_mc_count", mc_count, 1);

    frames(263, 2);
    check("t2_resync_search", resync, 1);
    check("t2_valid_search", mode_valid, 0);
    check("t2_add_line_held", add_line, 0);
    frames(263, 3);
    check("t2_add_line", add_line, 1);
    check("t2_mode_valid", mode_valid, 1);
    check("t2_frame_lines", frame_lines, 262);
    check("t2_mc_count", mc_count, 2);

    frames(625, 5);
    check("t3_is_pal", is_pal, 1);
    check("t3_add_line", add_line, 0);
    check("t3_frame_lines", frame_lines, 624);
    check("t3_mc_count", mc_count, 3);

    for (int i = 0; i < 990; i++) cyc(1, 1);
    check("t4_gen_before", generate_timing, 0);
    for (int i = 0; i < 15; i++) cyc(1, 1);
    check("t4_gen_lost", generate_timing, 1);
    check("t4_valid_lost", mode_valid, 0);
    check("t4_is_pal_held", is_pal, 1);
    cyc(0, 0);
    cyc(0, 0);
    check("t4_gen_resume", generate_timing, 0);
    frames(263, 4);
    check("t4_relock_add_line", add_line, 1);
    check("t4_relock_valid", mode_valid, 1);
    check("t4_mc_count", mc_count, 4);

    frames(525, 1);
    frames(500, 1);
    frames(525, 3);
    check("t5_no_lock", mode_valid, 0);
    force_generate_req = 1'b1;
    frames(525, 1);
    check("t5_force_gen", generate_timing, 1);
    check("t5_force_valid", mode_valid, 1);
    check("t5_mc_count", mc_count, 5);
    force_generate_req = 1'b0;

`ifdef SYNC_GLITCH_FILTER_EN
    for (int k = 0; k < 3; k++) drive_frame(525, 1'b1);
    check("t6_glitch_lines", frame_lines, 524);
    check("t6_glitch_valid", mode_valid, 1);
    check("t6_glitch_mc", mc_count, 5);
`endif

    drive_frame(200, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t7_reset_valid", mode_valid, 0);
    check("t7_reset_lines", frame_lines, 0);
    check("t7_reset_add", add_line, 0);
    reset = 1'b0;
    frames(525, 2);
    check("t7_after_valid", mode_valid, 0);
    check("t7_after_lines", frame_lines, 524);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
